// File: rtl/proc_pkg.sv
// ============================================================================
//  proc_pkg
//  Shared control-bit indices, register-zero index and datapath defaults.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  // RegWrite bit of a MEM/WB control word
  function automatic logic ctrl_regwrite(input logic [1:0] ctrl);
    return ctrl[CTRL_REGWRITE];
  endfunction

  // MemtoReg bit of a MEM/WB control word
  function automatic logic ctrl_memtoreg(input logic [1:0] ctrl);
    return ctrl[CTRL_MEMTOREG];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_mux.sv
// ============================================================================
//  wb_mux
//  Writeback select: load data when MemtoReg is set, otherwise ALU result.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] value
);

  assign value = mem_to_reg ? mem_data : alu_result;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
//  wb_regfile
//  Writeback stage, 2**ADDR_W-entry register file with two read ports and a
//  retired-write counter. Define REGFILE_BYPASS_EN for same-cycle write-through.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module wb_regfile
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_control,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_alu,
  input  logic [ADDR_W-1:0] wb_regdst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_value,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];
  logic              we;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .mem_to_reg (ctrl_memtoreg(wb_control)),
    .mem_data   (wb_data),
    .alu_result (wb_alu),
    .value      (wb_value)
  );

  // Register zero is excluded here, so it keeps its reset value forever
  assign we = ctrl_regwrite(wb_control) && (wb_regdst != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wb_regdst] <= wb_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (we) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through: ID sees the value being committed this cycle
  assign rs_data = (we && (rs_addr == wb_regdst)) ? wb_value : regs[rs_addr];
  assign rt_data = (we && (rt_addr == wb_regdst)) ? wb_value : regs[rt_addr];
`else
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];
`endif

endmodule

`default_nettype wire
